// File: rtl/dmem_responder_if.sv
// Memory-stage bus between the MIPS core (master) and dmem_responder (slave).
// The err signal exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_responder_if;
  logic        req_en;
  logic [3:0]  mem_wen;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err;

  modport master (output req_en, mem_wen, addr, size, wdata,
                  input  rdata, rvalid, stall, err);
  modport slave  (input  req_en, mem_wen, addr, size, wdata,
                  output rdata, rvalid, stall, err);
`else
  modport master (output req_en, mem_wen, addr, size, wdata,
                  input  rdata, rvalid, stall);
  modport slave  (input  req_en, mem_wen, addr, size, wdata,
                  output rdata, rvalid, stall);
`endif
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory for the core's M stage with optional wait states.
// Define DMEM_ALIGN_CHECK_EN to add misalignment detection and the err pulse.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [31:0] mem_array [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            wen_q, wen_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  store_q, store_d;
  logic                  mis_q, mis_d;

  logic                  req_store;
  logic                  req_mis;
  logic                  posted;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  stall;
  logic                  do_access;
  logic                  acc_store;
  logic                  acc_mis;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [3:0]            acc_wen;
  logic [31:0]           acc_wdata;
  logic                  mem_we;

  assign req_store = |bus.mem_wen;
  assign req_idx   = bus.addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = ((bus.size == 2'd1) && bus.addr[0]) ||
                   (bus.size[1] && (bus.addr[1:0] != 2'b00));
  assign bus.err = err_q;
`else
  logic unused_err;
  assign req_mis    = 1'b0;
  assign unused_err = err_q;
`endif

  // A misaligned store is never posted so that it gets a RESP cycle for err.
  assign posted = req_store && (WAIT_CYCLES == 0) && !req_mis;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    idx_d     = idx_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    store_d   = store_q;
    mis_d     = mis_q;
    stall     = 1'b0;
    do_access = 1'b0;
    mem_we    = 1'b0;
    acc_store = req_store;
    acc_mis   = req_mis;
    acc_idx   = req_idx;
    acc_wen   = bus.mem_wen;
    acc_wdata = bus.wdata;

    case (state_q)
      IDLE: begin
        if (bus.req_en) begin
          if (posted) begin
            mem_we = 1'b1;
          end else begin
            stall   = 1'b1;
            idx_d   = req_idx;
            wen_d   = bus.mem_wen;
            wdata_d = bus.wdata;
            store_d = req_store;
            mis_d   = req_mis;
            if (WAIT_CYCLES == 0) begin
              do_access = 1'b1;
              state_d   = RESP;
            end else begin
              cnt_d   = WAIT_INIT;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        stall     = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        acc_store = store_q;
        acc_mis   = mis_q;
        acc_idx   = idx_q;
        acc_wen   = wen_q;
        acc_wdata = wdata_q;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The access lands on the edge that enters RESP; rvalid/err mark that cycle.
    if (do_access) begin
      if (acc_store) begin
        mem_we = !acc_mis;
      end else begin
        rdata_d = acc_mis ? 32'h0 : mem_array[acc_idx];
      end
      rvalid_d = !acc_store;
      err_d    = acc_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wen_q    <= 4'h0;
      wdata_q  <= 32'h0;
      store_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      store_q  <= store_d;
      mis_q    <= mis_d;
    end
  end

  // Array is never cleared; reset only blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) begin
          mem_array[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0], bus.size};

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.stall  = stall;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with 0, 3 and 2 wait states.
// Alignment-error checks are compiled in when DMEM_ALIGN_CHECK_EN is defined.
module tb_dmem_responder;

  localparam int W0 = 0;
  localparam int W1 = 3;
  localparam int W2 = 2;

  logic        clk = 1'b0;
  logic        rst_v     [3];
  logic        req_en_v  [3];
  logic [3:0]  wen_v     [3];
  logic [31:0] addr_v    [3];
  logic [1:0]  size_v    [3];
  logic [31:0] wdata_v   [3];
  wire         stall_v   [3];
  wire         rvalid_v  [3];
  wire  [31:0] rdata_v   [3];
`ifdef DMEM_ALIGN_CHECK_EN
  wire         err_v     [3];
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Expected load results tagged with the instance number: {inst, data}.
  logic [33:0] sb_q [$];
  logic [31:0] model [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder_if u_if ();
    assign u_if.req_en  = req_en_v[g];
    assign u_if.mem_wen = wen_v[g];
    assign u_if.addr    = addr_v[g];
    assign u_if.size    = size_v[g];
    assign u_if.wdata   = wdata_v[g];
    assign stall_v[g]   = u_if.stall;
    assign rvalid_v[g]  = u_if.rvalid;
    assign rdata_v[g]   = u_if.rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    assign err_v[g]     = u_if.err;
`endif
    dmem_responder #(
      .ADDR_WIDTH (12),
      .WAIT_CYCLES((g == 0) ? W0 : (g == 1) ? W1 : W2)
    ) u_dut (
      .clk(clk),
      .rst(rst_v[g]),
      .bus(u_if)
    );
  end

  function automatic int waitOf(input int g);
    return (g == 0) ? W0 : (g == 1) ? W1 : W2;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
    end
  endtask

  // Every rvalid pulse must match the oldest outstanding load.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rvalid_v[k]) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_rvalid", 64'(k), 64'hFF);
        end else begin
          logic [33:0] exp_e;
          exp_e = sb_q.pop_front();
          checkOutput("load_data", {30'b0, 2'(k), rdata_v[k]}, {30'b0, exp_e});
        end
      end
    end
  end

  // Holds the request until a cycle with stall=0, as the core does.
  task automatic applyStimulus(input int g, input logic [31:0] a, input logic [3:0] wen,
                               input logic [31:0] d, input logic [1:0] sz,
                               input int exp_stalls, input int exp_errs, input string tag);
    int   stalls = 0;
    int   errs   = 0;
    int   cycles = 0;
    logic st;
    logic rv_last;
    req_en_v[g] = 1'b1;
    addr_v[g]   = a;
    wen_v[g]    = wen;
    wdata_v[g]  = d;
    size_v[g]   = sz;
    do begin
      @(negedge clk);
      st      = stall_v[g];
      rv_last = rvalid_v[g];
      if (st) stalls++;
`ifdef DMEM_ALIGN_CHECK_EN
      if (err_v[g]) errs++;
`endif
      cycles++;
      @(posedge clk);
      #1;
    end while (st && cycles < 64);
    req_en_v[g] = 1'b0;
    wen_v[g]    = 4'h0;
    if (st) checkOutput({tag, "_timeout"}, 64'(cycles), 64'd0);
    checkOutput({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    checkOutput({tag, "_rvalid_last"}, 64'(rv_last), 64'(wen == 4'h0));
`ifdef DMEM_ALIGN_CHECK_EN
    checkOutput({tag, "_err"}, 64'(errs), 64'(exp_errs));
`else
    if (exp_errs != 0) checkOutput({tag, "_err_unsupported"}, 64'(errs), 64'(exp_errs));
`endif
    // The cycle after completion must be quiet: no re-accept of the retired request.
    @(negedge clk);
    checkOutput({tag, "_idle_stall"}, 64'(stall_v[g]), 64'd0);
    checkOutput({tag, "_idle_rvalid"}, 64'(rvalid_v[g]), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic doStore(input int g, input logic [31:0] a, input logic [3:0] wen,
                         input logic [31:0] d, input logic [1:0] sz, input string tag);
    applyStimulus(g, a, wen, d, sz, (waitOf(g) == 0) ? 0 : 1 + waitOf(g), 0, tag);
  endtask

  task automatic doLoad(input int g, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] expected, input int exp_stalls,
                        input int exp_errs, input string tag);
    sb_q.push_back({2'(g), expected});
    applyStimulus(g, a, 4'h0, 32'h0, sz, exp_stalls, exp_errs, tag);
    checkOutput({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int          k;
    logic [3:0]  wen;
    logic [31:0] d;

    for (int g = 0; g < 3; g++) begin
      rst_v[g]    = 1'b1;
      req_en_v[g] = 1'b0;
      wen_v[g]    = 4'h0;
      addr_v[g]   = 32'h0;
      size_v[g]   = 2'd2;
      wdata_v[g]  = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) rst_v[g] = 1'b0;

    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checkOutput("reset_stall", 64'(stall_v[g]), 64'd0);
      checkOutput("reset_rvalid", 64'(rvalid_v[g]), 64'd0);
      checkOutput("reset_rdata", 64'(rdata_v[g]), 64'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      checkOutput("reset_err", 64'(err_v[g]), 64'd0);
`endif
    end
    @(posedge clk);
    #1;

    $display("[TB] zero-wait posted stores, byte merge, wrap");
    doStore(0, 32'h10, 4'b1111, 32'hDEADBEEF, 2'd2, "st_word");
    doLoad (0, 32'h10, 2'd2, 32'hDEADBEEF, 1, 0, "ld_word");
    doStore(0, 32'h13, 4'b1000, 32'h5A5A5A5A, 2'd0, "st_byte");
    doLoad (0, 32'h10, 2'd2, 32'h5AADBEEF, 1, 0, "ld_merged");
    doStore(0, 32'h4000, 4'b1111, 32'h11111111, 2'd2, "st_wrap");
    doLoad (0, 32'h0000, 2'd2, 32'h11111111, 1, 0, "ld_wrap");
    doStore(0, 32'h14, 4'b0011, 32'h12341234, 2'd1, "st_half_lo");
    doStore(0, 32'h16, 4'b1100, 32'hABCDABCD, 2'd1, "st_half_hi");
    doLoad (0, 32'h16, 2'd1, 32'hABCD1234, 1, 0, "ld_half_fullword");

    $display("[TB] randomized lane stores against a word model");
    for (int i = 0; i < 4; i++) begin
      model[i] = $urandom;
      doStore(0, 32'h100 + 32'(4 * i), 4'b1111, model[i], 2'd2, "rnd_init");
    end
    for (int i = 0; i < 8; i++) begin
      k   = int'($urandom_range(0, 3));
      wen = 4'($urandom_range(1, 15));
      d   = $urandom;
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) model[k][8*b +: 8] = d[8*b +: 8];
      end
      doStore(0, 32'h100 + 32'(4 * k), wen, d, 2'd2, "rnd_st");
      doLoad (0, 32'h100 + 32'(4 * k), 2'd2, model[k], 1, 0, "rnd_ld");
    end

    $display("[TB] three wait states");
    doStore(1, 32'h20, 4'b1111, 32'h12345678, 2'd2, "w3_st");
    doLoad (1, 32'h20, 2'd2, 32'h12345678, 4, 0, "w3_ld");

    $display("[TB] two wait states, reset drops a pending store");
    doStore(2, 32'h30, 4'b1111, 32'h0BADF00D, 2'd2, "w2_preload");
    req_en_v[2] = 1'b1;
    addr_v[2]   = 32'h30;
    wen_v[2]    = 4'b1111;
    wdata_v[2]  = 32'hCAFEF00D;
    size_v[2]   = 2'd2;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("w2_pending_stall", 64'(stall_v[2]), 64'd1);
    rst_v[2]    = 1'b1;
    req_en_v[2] = 1'b0;
    wen_v[2]    = 4'h0;
    @(posedge clk);
    #1;
    rst_v[2] = 1'b0;
    @(negedge clk);
    checkOutput("w2_post_reset_stall", 64'(stall_v[2]), 64'd0);
    checkOutput("w2_post_reset_rdata", 64'(rdata_v[2]), 64'd0);
    @(posedge clk);
    #1;
    doLoad(2, 32'h30, 2'd2, 32'h0BADF00D, 3, 0, "w2_ld_after_reset");

`ifdef DMEM_ALIGN_CHECK_EN
    $display("[TB] alignment faults");
    doStore(0, 32'h40, 4'b1111, 32'h77665544, 2'd2, "al_preload");
    applyStimulus(0, 32'h41, 4'b0110, 32'h99999999, 2'd1, 1, 1, "al_half_st");
    doLoad(0, 32'h40, 2'd2, 32'h77665544, 1, 0, "al_unchanged");
    doLoad(0, 32'h42, 2'd2, 32'h0, 1, 1, "al_word_ld");
    doLoad(1, 32'h21, 2'd1, 32'h0, 4, 1, "al_w3_half_ld");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
